// File: rtl/pe_rf_read_if.sv
// Signal bundle between decode/EX/WB and the pe_rf_read stage: ID request, EX forward,
// WB write port and the registered ID/EX outputs. Stage latency is one cycle; iStall holds.
`ifndef DEF_PE_DATA_WIDTH
`define DEF_PE_DATA_WIDTH 32
`endif
`ifndef DEF_RF_INDEX_WIDTH
`define DEF_RF_INDEX_WIDTH 5
`endif

interface pe_rf_read_if;
   localparam int DW = `DEF_PE_DATA_WIDTH;
   localparam int IW = `DEF_RF_INDEX_WIDTH;

   logic          iStall;
   logic          iFlush;
   logic          iID_Valid;
   logic [IW-1:0] iID_Read_Addr_A;
   logic [IW-1:0] iID_Read_Addr_B;
   logic          iID_Write_RF_Enable;
   logic [IW-1:0] iID_Write_RF_Address;
   logic          iEX_Fwd_Enable;
   logic [IW-1:0] iEX_Fwd_Addr;
   logic [DW-1:0] iEX_Fwd_Data;
   logic          iWB_RF_Writeback_Enable;
   logic [IW-1:0] iWB_RF_Write_Addr;
   logic [DW-1:0] iWB_RF_Write_Data;
   logic          oEX_Valid;
   logic [DW-1:0] oEX_Operand_A;
   logic [DW-1:0] oEX_Operand_B;
   logic          oEX_Write_RF_Enable;
   logic [IW-1:0] oEX_Write_RF_Address;

   modport master (
      output iStall, iFlush, iID_Valid, iID_Read_Addr_A, iID_Read_Addr_B,
             iID_Write_RF_Enable, iID_Write_RF_Address,
             iEX_Fwd_Enable, iEX_Fwd_Addr, iEX_Fwd_Data,
             iWB_RF_Writeback_Enable, iWB_RF_Write_Addr, iWB_RF_Write_Data,
      input  oEX_Valid, oEX_Operand_A, oEX_Operand_B,
             oEX_Write_RF_Enable, oEX_Write_RF_Address
   );

   modport slave (
      input  iStall, iFlush, iID_Valid, iID_Read_Addr_A, iID_Read_Addr_B,
             iID_Write_RF_Enable, iID_Write_RF_Address,
             iEX_Fwd_Enable, iEX_Fwd_Addr, iEX_Fwd_Data,
             iWB_RF_Writeback_Enable, iWB_RF_Write_Addr, iWB_RF_Write_Data,
      output oEX_Valid, oEX_Operand_A, oEX_Operand_B,
             oEX_Write_RF_Enable, oEX_Write_RF_Address
   );
endinterface

// File: rtl/pe_rf_read.sv
// PE register file + operand read into ID/EX: 1-cycle latency; iStall holds, iFlush bubbles (flush wins).
// PE_RF_BYPASS_EN adds EX/WB forwarding and WB refresh of held operands; default build reads the array only.
`ifndef DEF_PE_DATA_WIDTH
`define DEF_PE_DATA_WIDTH 32
`endif
`ifndef DEF_RF_INDEX_WIDTH
`define DEF_RF_INDEX_WIDTH 5
`endif

module pe_rf_read #(
   parameter int unsigned ZERO_REG = 1
) (
   input  logic         iClk,
   input  logic         iReset,
   pe_rf_read_if.slave  bus
);
   localparam int DW    = `DEF_PE_DATA_WIDTH;
   localparam int IW    = `DEF_RF_INDEX_WIDTH;
   localparam int DEPTH = 1 << IW;
   localparam bit ZR    = (ZERO_REG != 0);

   logic [DW-1:0] rf_q [DEPTH];
   logic          wb_commit;

   logic          valid_q;
   logic          we_q;
   logic [IW-1:0] waddr_q;
   logic [DW-1:0] opa_q, opa_d;
   logic [DW-1:0] opb_q, opb_d;
   logic [IW-1:0] srca_q;
   logic [IW-1:0] srcb_q;

   assign wb_commit = bus.iWB_RF_Writeback_Enable && !(ZR && bus.iWB_RF_Write_Addr == '0);

   // Array is deliberately outside reset so a WB write in a reset cycle still lands.
   always_ff @(posedge iClk) begin
      if (wb_commit) begin
         rf_q[bus.iWB_RF_Write_Addr] <= bus.iWB_RF_Write_Data;
      end
   end

   always_comb begin
      opa_d = rf_q[bus.iID_Read_Addr_A];
      opb_d = rf_q[bus.iID_Read_Addr_B];
`ifdef PE_RF_BYPASS_EN
      if (bus.iWB_RF_Writeback_Enable && bus.iWB_RF_Write_Addr == bus.iID_Read_Addr_A) begin
         opa_d = bus.iWB_RF_Write_Data;
      end
      if (bus.iWB_RF_Writeback_Enable && bus.iWB_RF_Write_Addr == bus.iID_Read_Addr_B) begin
         opb_d = bus.iWB_RF_Write_Data;
      end
      if (bus.iEX_Fwd_Enable && bus.iEX_Fwd_Addr == bus.iID_Read_Addr_A) begin
         opa_d = bus.iEX_Fwd_Data;
      end
      if (bus.iEX_Fwd_Enable && bus.iEX_Fwd_Addr == bus.iID_Read_Addr_B) begin
         opb_d = bus.iEX_Fwd_Data;
      end
`endif
      if (ZR && bus.iID_Read_Addr_A == '0) begin
         opa_d = '0;
      end
      if (ZR && bus.iID_Read_Addr_B == '0) begin
         opb_d = '0;
      end
   end

   always_ff @(posedge iClk) begin
      if (iReset) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         opa_q   <= '0;
         opb_q   <= '0;
         srca_q  <= '0;
         srcb_q  <= '0;
      end else if (bus.iFlush) begin
         valid_q <= 1'b0;
         we_q    <= 1'b0;
      end else if (bus.iStall) begin
`ifdef PE_RF_BYPASS_EN
         // Only WB refreshes a held operand; the EX result reaches it via WB next cycle.
         if (wb_commit && srca_q == bus.iWB_RF_Write_Addr) begin
            opa_q <= bus.iWB_RF_Write_Data;
         end
         if (wb_commit && srcb_q == bus.iWB_RF_Write_Addr) begin
            opb_q <= bus.iWB_RF_Write_Data;
         end
`endif
      end else begin
         valid_q <= bus.iID_Valid;
         we_q    <= bus.iID_Write_RF_Enable & bus.iID_Valid;
         waddr_q <= bus.iID_Write_RF_Address;
         opa_q   <= opa_d;
         opb_q   <= opb_d;
         srca_q  <= bus.iID_Read_Addr_A;
         srcb_q  <= bus.iID_Read_Addr_B;
      end
   end

`ifndef PE_RF_BYPASS_EN
   logic unused_nobypass;
   assign unused_nobypass = ^{bus.iEX_Fwd_Enable, bus.iEX_Fwd_Addr, bus.iEX_Fwd_Data,
                              srca_q, srcb_q};
`endif

   assign bus.oEX_Valid            = valid_q;
   assign bus.oEX_Operand_A        = opa_q;
   assign bus.oEX_Operand_B        = opb_q;
   assign bus.oEX_Write_RF_Enable  = we_q;
   assign bus.oEX_Write_RF_Address = waddr_q;

endmodule

// File: tb/tb_pe_rf_read.sv
// Bench for pe_rf_read: directed cycle table with hand-derived expectations, then random traffic vs a model.
module tb_pe_rf_read;
`ifdef PE_RF_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   pe_rf_read_if ifc();
   pe_rf_read #(.ZERO_REG(1)) dut (.iClk(clk), .iReset(rst), .bus(ifc.slave));

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit        rst, stall, flush, vld;
      bit [4:0]  ra, rb;
      bit        we;
      bit [4:0]  wa;
      bit        exen;
      bit [4:0]  exa;
      bit [31:0] exd;
      bit        wben;
      bit [4:0]  wba;
      bit [31:0] wbd;
      bit        e_vld;
      bit [31:0] e_a, e_b;
      bit        e_we;
      bit [4:0]  e_wa;
      bit        chk;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(int r, int st, int fl, int v, int ra, int rb, int we, int wa,
                               int exen, int exa, int exd, int wben, int wba, int wbd,
                               int evld, int ea, int eb, int ewe, int ewa, int chk);
      vec_t t;
      t.rst = r[0]; t.stall = st[0]; t.flush = fl[0]; t.vld = v[0];
      t.ra = 5'(ra); t.rb = 5'(rb); t.we = we[0]; t.wa = 5'(wa);
      t.exen = exen[0]; t.exa = 5'(exa); t.exd = 32'(exd);
      t.wben = wben[0]; t.wba = 5'(wba); t.wbd = 32'(wbd);
      t.e_vld = evld[0]; t.e_a = 32'(ea); t.e_b = 32'(eb);
      t.e_we = ewe[0]; t.e_wa = 5'(ewa); t.chk = chk[0];
      return t;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input vec_t t);
      rst                         = t.rst;
      ifc.iStall                  = t.stall;
      ifc.iFlush                  = t.flush;
      ifc.iID_Valid               = t.vld;
      ifc.iID_Read_Addr_A         = t.ra;
      ifc.iID_Read_Addr_B         = t.rb;
      ifc.iID_Write_RF_Enable     = t.we;
      ifc.iID_Write_RF_Address    = t.wa;
      ifc.iEX_Fwd_Enable          = t.exen;
      ifc.iEX_Fwd_Addr            = t.exa;
      ifc.iEX_Fwd_Data            = t.exd;
      ifc.iWB_RF_Writeback_Enable = t.wben;
      ifc.iWB_RF_Write_Addr       = t.wba;
      ifc.iWB_RF_Write_Data       = t.wbd;
   endtask

   // Reference model: register contents as a plain array plus the expected ID/EX record.
   logic [31:0] mem [32];
   logic        m_vld, m_we, m_known;
   logic [31:0] m_a, m_b;
   logic [4:0]  m_wa, m_sa, m_sb;

   function automatic logic [31:0] m_read(input logic [4:0] idx);
      if (idx == 5'd0) return 32'd0;
      if (BYP && ifc.iEX_Fwd_Enable && ifc.iEX_Fwd_Addr == idx) return ifc.iEX_Fwd_Data;
      if (BYP && ifc.iWB_RF_Writeback_Enable && ifc.iWB_RF_Write_Addr == idx) return ifc.iWB_RF_Write_Data;
      return mem[idx];
   endfunction

   task automatic model_edge();
      logic [31:0] a, b;
      logic        wb_live;
      a = m_read(ifc.iID_Read_Addr_A);
      b = m_read(ifc.iID_Read_Addr_B);
      wb_live = ifc.iWB_RF_Writeback_Enable && ifc.iWB_RF_Write_Addr != 5'd0;
      if (rst) begin
         m_vld = 0; m_we = 0; m_a = 0; m_b = 0; m_wa = 0; m_sa = 0; m_sb = 0; m_known = 1;
      end else if (ifc.iFlush) begin
         m_vld = 0; m_we = 0; m_known = 0;
      end else if (ifc.iStall) begin
         if (BYP && wb_live && ifc.iWB_RF_Write_Addr == m_sa) m_a = ifc.iWB_RF_Write_Data;
         if (BYP && wb_live && ifc.iWB_RF_Write_Addr == m_sb) m_b = ifc.iWB_RF_Write_Data;
      end else begin
         m_vld = ifc.iID_Valid;
         m_we  = ifc.iID_Valid && ifc.iID_Write_RF_Enable;
         m_wa  = ifc.iID_Write_RF_Address;
         m_a = a; m_b = b;
         m_sa = ifc.iID_Read_Addr_A; m_sb = ifc.iID_Read_Addr_B;
         m_known = 1;
      end
      if (wb_live) mem[ifc.iWB_RF_Write_Addr] = ifc.iWB_RF_Write_Data;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input int n);
      check($sformatf("rnd%0d valid", n), 32'(ifc.oEX_Valid), 32'(m_vld));
      check($sformatf("rnd%0d we", n), 32'(ifc.oEX_Write_RF_Enable), 32'(m_we));
      if (m_known) begin
         check($sformatf("rnd%0d op_a", n), ifc.oEX_Operand_A, m_a);
         check($sformatf("rnd%0d op_b", n), ifc.oEX_Operand_B, m_b);
         check($sformatf("rnd%0d waddr", n), 32'(ifc.oEX_Write_RF_Address), 32'(m_wa));
      end
   endtask

   initial begin
      vec_t t;
      // rst st fl vld ra rb we wa | exen exa exd | wben wba wbd | evld ea eb ewe ewa chk
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,1));
      tbl.push_back(mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 1,3,32'h12345678, 0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,1, 3,0,1,9, 0,0,0, 0,0,0, 1,32'h12345678,0,1,9,1));
      tbl.push_back(mk(0,0,0,1, 0,0,0,0, 0,0,0, 1,0,32'hFFFFFFFF, 1,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,1, 0,3,0,0, 0,0,0, 0,0,0, 1,0,32'h12345678,0,0,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 1,5,32'h5, 0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,1, 5,5,0,0, 1,5,32'hAAAA0000, 1,5,32'h5555, 1,
                       BYP ? 32'hAAAA0000 : 32'h5, BYP ? 32'hAAAA0000 : 32'h5, 0,0,1));
      tbl.push_back(mk(0,0,0,1, 5,5,0,0, 0,0,0, 1,5,32'h6666, 1,
                       BYP ? 32'h6666 : 32'h5555, BYP ? 32'h6666 : 32'h5555, 0,0,1));
      tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0, 1,7,32'h1, 0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,1, 7,3,1,2, 0,0,0, 0,0,0, 1,32'h1,32'h12345678,1,2,1));
      tbl.push_back(mk(0,1,0,0, 3,3,0,4, 0,0,0, 0,0,0, 1,32'h1,32'h12345678,1,2,1));
      tbl.push_back(mk(0,1,0,0, 3,3,0,4, 1,7,32'h99, 1,7,32'h77, 1,
                       BYP ? 32'h77 : 32'h1, 32'h12345678,1,2,1));
      tbl.push_back(mk(0,1,0,1, 1,1,1,8, 0,0,0, 0,0,0, 1,
                       BYP ? 32'h77 : 32'h1, 32'h12345678,1,2,1));
      tbl.push_back(mk(0,0,0,1, 7,0,1,6, 0,0,0, 0,0,0, 1,32'h77,0,1,6,1));
      tbl.push_back(mk(0,1,1,1, 3,3,1,4, 0,0,0, 0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(0,1,0,1, 3,3,1,4, 0,0,0, 0,0,0, 0,0,0,0,0,0));
      tbl.push_back(mk(0,0,0,0, 3,0,1,1, 0,0,0, 1,1,32'h11, 0,32'h12345678,0,0,1,1));
      tbl.push_back(mk(0,0,0,0, 1,0,1,2, 0,0,0, 1,2,32'h22, 0,32'h11,0,0,2,1));
      tbl.push_back(mk(0,0,0,0, 2,0,1,3, 0,0,0, 1,3,32'h33, 0,32'h22,0,0,3,1));
      tbl.push_back(mk(0,0,0,0, 3,0,1,4, 0,0,0, 1,4,32'h44, 0,32'h33,0,0,4,1));
      tbl.push_back(mk(0,0,0,1, 4,1,1,5, 0,0,0, 0,0,0, 1,32'h44,32'h11,1,5,1));
      tbl.push_back(mk(0,1,0,0, 4,1,1,5, 0,0,0, 0,0,0, 1,32'h44,32'h11,1,5,1));
      tbl.push_back(mk(1,1,0,1, 4,1,1,5, 0,0,0, 1,6,32'h66, 0,0,0,0,0,1));
      tbl.push_back(mk(0,0,0,1, 6,0,0,0, 0,0,0, 0,0,0, 1,32'h66,0,0,0,1));

      drive(tbl[0]);
      foreach (tbl[i]) begin
         t = tbl[i];
         drive(t);
         tick();
         check($sformatf("row%0d valid", i), 32'(ifc.oEX_Valid), 32'(t.e_vld));
         check($sformatf("row%0d we", i), 32'(ifc.oEX_Write_RF_Enable), 32'(t.e_we));
         if (t.chk) begin
            check($sformatf("row%0d op_a", i), ifc.oEX_Operand_A, t.e_a);
            check($sformatf("row%0d op_b", i), ifc.oEX_Operand_B, t.e_b);
            check($sformatf("row%0d waddr", i), 32'(ifc.oEX_Write_RF_Address), 32'(t.e_wa));
         end
      end

      // Random phase: reset, fill the array so every read is defined, then mixed traffic.
      t = mk(1,0,0,0, 0,0,0,0, 0,0,0, 0,0,0, 0,0,0,0,0,0);
      drive(t);
      model_edge();
      tick();
      check_model(-1);
      for (int r = 1; r < 32; r++) begin
         t = mk(0,0,0,0, 0,0,0,0, 0,0,0, 1,r,int'($urandom), 0,0,0,0,0,0);
         drive(t);
         model_edge();
         tick();
         check_model(-1);
      end
      for (int n = 0; n < 1500; n++) begin
         rst                         = ($urandom_range(0, 99) < 2);
         ifc.iStall                  = ($urandom_range(0, 99) < 30);
         ifc.iFlush                  = ($urandom_range(0, 99) < 8);
         ifc.iID_Valid               = 1'($urandom);
         ifc.iID_Read_Addr_A         = 5'($urandom_range(0, 7));
         ifc.iID_Read_Addr_B         = 5'($urandom_range(0, 7));
         ifc.iID_Write_RF_Enable     = 1'($urandom);
         ifc.iID_Write_RF_Address    = 5'($urandom_range(0, 7));
         ifc.iEX_Fwd_Enable          = 1'($urandom);
         ifc.iEX_Fwd_Addr            = 5'($urandom_range(0, 7));
         ifc.iEX_Fwd_Data            = $urandom;
         ifc.iWB_RF_Writeback_Enable = 1'($urandom);
         ifc.iWB_RF_Write_Addr       = 5'($urandom_range(0, 7));
         ifc.iWB_RF_Write_Data       = $urandom;
         model_edge();
         tick();
         check_model(n);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/pe_rf_read.md
# pe_rf_read

Register-file read stage for the 32-bit 4-stage PE. It holds the PE register file and accepts the write-back port driven by the WB stage. Each cycle it reads two source operands for the decoded instruction, resolves RAW hazards by forwarding, and registers the operands plus destination info into the ID/EX pipeline register. It is the reading end of the RF write-back interface.

## Interface
**Parameters**
- ZERO_REG, 1, when 1 register 0 reads as 0 and ignores writes.
- Data width is `DEF_PE_DATA_WIDTH`. Index width is `DEF_RF_INDEX_WIDTH`. Depth is 2^`DEF_RF_INDEX_WIDTH`.

**Ports**
- iClk  in  1  system clock, posedge.
- iReset  in  1  reset, synchronous, active-high.
- iStall  in  1  hold ID/EX register.
- iFlush  in  1  insert bubble into ID/EX.
- iID_Valid  in  1  decoded instruction valid.
- iID_Read_Addr_A / iID_Read_Addr_B  in  RF_INDEX  source indices.
- iID_Write_RF_Enable  in  1  instruction writes RF.
- iID_Write_RF_Address  in  RF_INDEX  destination index.
- iEX_Fwd_Enable  in  1  EX result valid this cycle; it is written to RF one cycle later.
- iEX_Fwd_Addr  in  RF_INDEX  EX destination.
- iEX_Fwd_Data  in  DATA  EX result.
- iWB_RF_Writeback_Enable  in  1  WB write enable.
- iWB_RF_Write_Addr  in  RF_INDEX  WB write index.
- iWB_RF_Write_Data  in  DATA  WB write data.
- oEX_Valid  out  1  ID/EX valid.
- oEX_Operand_A / oEX_Operand_B  out  DATA  registered operands.
- oEX_Write_RF_Enable  out  1  registered destination enable.
- oEX_Write_RF_Address  out  RF_INDEX  registered destination.

## Operation
- **RF write:** at posedge, the RF array takes iWB_RF_Write_Data at iWB_RF_Write_Addr if iWB_RF_Writeback_Enable is 1. If ZERO_REG=1, writes to index 0 are dropped.
- **Operand select, per port, highest priority first (bypass build):**
  1. ZERO_REG and index 0 gives 0.
  2. iEX_Fwd_Enable and address match gives iEX_Fwd_Data.
  3. iWB_RF_Writeback_Enable and address match gives iWB_RF_Write_Data.
  4. Otherwise the array value.
- **ID/EX update, evaluated in priority order:**
  - iReset: all ID/EX registers go to 0.
  - iFlush: oEX_Valid=0 and oEX_Write_RF_Enable=0. Operands, address and source indices are don't-care.
  - iStall: all fields hold, except the refresh rule below.
  - Otherwise: load the selected operands, iID_Valid, iID_Write_RF_Enable and iID_Write_RF_Address, plus the source indices into internal registers.
- **oEX_Write_RF_Enable** is gated with valid: it equals iID_Write_RF_Enable AND iID_Valid.
- **Stall refresh (bypass build only):** while iStall=1 and iFlush=0, a held operand whose stored source index matches an active WB write (non-zero when ZERO_REG=1) is replaced by iWB_RF_Write_Data. It is not replaced from the EX forward. Each port is refreshed independently.
- **Flush and stall together:** flush wins.
- **Array reset:** the array is not reset. Contents are undefined until written.

## Timing
- Read latency: ID inputs sampled at edge N appear at the EX outputs after edge N. One cycle.
- Write-to-read: a WB write and a read of the same index in the same cycle returns the new data in the bypass build.
- Reset values: oEX_Valid=0, oEX_Operand_A=0, oEX_Operand_B=0, oEX_Write_RF_Enable=0, oEX_Write_RF_Address=0.
- Reset mid-stall: reset wins. A WB write in the reset cycle is still committed to the array.
- No combinational path from inputs to outputs.

## Configuration
- Macro: `PE_RF_BYPASS_EN`.
- **Defined:**
  - Forwarding priority as listed in Operation.
  - Stall refresh active.
  - Same-cycle WB write/read returns the new data.
- **Undefined:**
  - Operands come from ZERO_REG logic or the array only.
  - iEX_Fwd_* inputs are ignored.
  - No stall refresh.
  - A same-cycle read returns the old array value.
  - The compiler must insert NOPs to cover hazards.

## Test plan
- **Reset.** Assert iReset for 2 cycles, then release. All outputs are 0.
- **Write then read.** WB writes r3=0x12345678. Next cycle ID reads A=r3, B=r0. oEX_Operand_A=0x12345678 and oEX_Operand_B=0. Also write r0=0xFFFFFFFF and read r0: result is 0.
- **Forwarding priority (bypass build).** In the same cycle: EX forwards r5=0xAAAA0000, WB writes r5=0x5555, ID reads r5. Operand is 0xAAAA0000. Without EX forward the operand is 0x5555. Non-bypass build returns the old r5 value.
- **Stall refresh.** ID reads r7 (old value 0x1), then iStall=1 for 3 cycles. In stall cycle 2, WB writes r7=0x77. oEX_Operand_A becomes 0x77 after that edge and stays 0x77 after the stall releases. Non-bypass build holds 0x1.
- **Flush vs stall.** Assert iStall=1 and iFlush=1 with a valid instruction held. Next cycle oEX_Valid=0 and oEX_Write_RF_Enable=0.
- **Back-to-back dependency.** Run 4 dependent writes r1..r4 at full throughput with iID_Write_RF_Enable=1 and iID_Valid=0. Destination enable is output as 0. Operands match a reference model.
